// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, instr} between imem and decode,
// with branch flush, sticky overflow and an optional empty-queue bypass.
module fetch_queue #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 16,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 2,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_instr,
    input  logic [PC_W-1:0]              in_pc,
    output logic                         in_ready,
    output logic                         almost_full,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_instr,
    output logic [PC_W-1:0]              out_pc,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic   empty, bypass_path, push, pop, bypass_take, wr_en, rd_en;
    entry_t out_e;

    always_comb begin
        empty       = (count_q == '0);
        in_ready    = flush || (count_q < CW'(DEPTH));
        almost_full = (int'(count_q) >= DEPTH - AF_LEVEL);
        bypass_path = (BYPASS != 0) && empty;

        out_valid = !flush && (bypass_path ? in_valid : !empty);
        out_e     = bypass_path ? entry_t'{pc: in_pc, instr: in_instr} : mem_q[rd_ptr_q];
        if (!out_valid)
            out_e = '0;
        out_pc    = out_e.pc;
        out_instr = out_e.instr;

        push = in_valid && in_ready && !flush;
        pop  = out_valid && out_ready;
        // An entry consumed straight from the input never touches storage.
        bypass_take = bypass_path && push && pop;
        wr_en       = push && !bypass_take;
        rd_en       = pop && !bypass_take;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en)
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (rd_en)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        count_d = count_q + CW'(wr_en) - CW'(rd_en);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        overflow_d = overflow_q || (in_valid && !in_ready && !flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem_q[wr_ptr_q] <= entry_t'{pc: in_pc, instr: in_instr};
    end

    assign count    = count_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Random + directed bench: two configurations (DEPTH=4 registered, DEPTH=3 bypass)
// share one stimulus stream and are each checked against a queue-based model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [15:0] in_instr, in_pc;

    logic        rdy0, af0, ov0, ovf0, rdy1, af1, ov1, ovf1;
    logic [15:0] oi0, op0, oi1, op1;
    logic [2:0]  cnt0;
    logic [1:0]  cnt1;

    int total = 0;
    int bad   = 0;
    logic [15:0] pc_n = 16'h0;

    logic [31:0] mq [2][$];
    logic        movf [2];

    always #5 clk = ~clk;

    fetch_queue #(.DATA_W(16), .PC_W(16), .DEPTH(4), .AF_LEVEL(2), .BYPASS(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .in_ready(rdy0), .almost_full(af0), .out_valid(ov0),
        .out_instr(oi0), .out_pc(op0), .out_ready(out_ready), .count(cnt0), .overflow(ovf0));

    fetch_queue #(.DATA_W(16), .PC_W(16), .DEPTH(3), .AF_LEVEL(2), .BYPASS(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .in_ready(rdy1), .almost_full(af1), .out_valid(ov1),
        .out_instr(oi1), .out_pc(op1), .out_ready(out_ready), .count(cnt1), .overflow(ovf1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check one DUT's pre-edge outputs, then advance its model across the edge.
    task automatic model(input int k, input int d, input int b, input logic [31:0] g_cnt,
                         input logic g_rdy, input logic g_af, input logic g_ov,
                         input logic [31:0] g_data, input logic g_ovf);
        int          n;
        logic        e_ov, do_pop, do_push;
        logic [31:0] e_data;
        n = mq[k].size();
        e_data = 32'h0;
        if (flush)                begin e_ov = 1'b0; end
        else if (b != 0 && n == 0) begin e_ov = in_valid; e_data = {in_pc, in_instr}; end
        else begin e_ov = (n != 0); if (n != 0) e_data = mq[k][0]; end

        chk($sformatf("count%0d", k), g_cnt, n);
        chk($sformatf("in_ready%0d", k), 32'(g_rdy), 32'(flush || n < d));
        chk($sformatf("almost_full%0d", k), 32'(g_af), 32'(n >= d - 2));
        chk($sformatf("out_valid%0d", k), 32'(g_ov), 32'(e_ov));
        if (e_ov) chk($sformatf("out_data%0d", k), g_data, e_data);
        chk($sformatf("overflow%0d", k), 32'(g_ovf), 32'(movf[k]));

        if (flush) begin
            mq[k].delete();
        end else begin
            do_pop  = e_ov && out_ready;
            do_push = in_valid && n < d;
            if (in_valid && n >= d) movf[k] = 1'b1;
            if (!(b != 0 && n == 0 && do_pop)) begin
                if (do_pop)  void'(mq[k].pop_front());
                if (do_push) mq[k].push_back({in_pc, in_instr});
            end
        end
    endtask

    // Inputs are applied at negedge; outputs sampled 1ns later, well before posedge.
    task automatic step(input logic v, input logic r, input logic f);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_pc     = pc_n;
        in_instr  = 16'($urandom);
        pc_n      = pc_n + 16'd2;
        #1;
        model(0, 4, 0, 32'(cnt0), rdy0, af0, ov0, {op0, oi0}, ovf0);
        model(1, 3, 1, 32'(cnt1), rdy1, af1, ov1, {op1, oi1}, ovf1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted mid-phase; state must clear without waiting for an edge.
    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_count0", 32'(cnt0), 0);
        chk("rst_count1", 32'(cnt1), 0);
        chk("rst_valid0", 32'(ov0), 0);
        chk("rst_valid1", 32'(ov1), 0);
        chk("rst_ready", 32'({rdy0, rdy1}), 32'h3);
        chk("rst_af", 32'({af0, af1}), 0);
        chk("rst_ovf", 32'({ovf0, ovf1}), 0);
        chk("rst_pc", 32'({op0, op1}), 0);
        for (int k = 0; k < 2; k++) begin mq[k].delete(); movf[k] = 1'b0; end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        movf[0] = 1'b0; movf[1] = 1'b0;
        @(negedge clk);
        do_reset();

        // Fill to full, overflow, then drain in order.
        pc_n = 16'h0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);

        // Bypass on an empty queue.
        pc_n = 16'h10;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Flush with a stored backlog and a live input.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // Full-throughput streaming with a standing backlog (pointer wrap).
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

        // Reset while two entries are held.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5,
                      $urandom_range(0, 29) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
